permutation_stream: RTL

PERMUTATION_STREAM -- requirements
Module: permutation_stream

---
 rtl/permutation_stream.sv | 129 ++++++++++++
 1 files changed

// File: rtl/permutation_stream.sv
// permutation_stream
//   Streams DEPTH slices of N*N bits per block through a bit permutation with
//   a single output register (latency 1, full throughput with back-pressure).
//   Slice bit index i = y*N + x.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   start, mode     begin a block (sampled in IDLE); permutation select latched on start
//                   00 bypass, 01 transpose, 10 row rotate, 11 inverse row rotate
//   in_valid/in_ready/in_data     input slice handshake
//   out_valid/out_ready/out_data  output slice handshake
//   out_last        held slice is the last slice of the block
//   busy            FSM not in IDLE
//   done            one-cycle pulse when the block completes
module permutation_stream #(
    parameter int N     = 5,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    input  logic [N*N-1:0]   in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [N*N-1:0]   out_data,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
);
    localparam int W  = N * N;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [1:0]    mode_q;
    logic [CW-1:0] in_cnt, out_cnt;
    logic          out_valid_q, out_last_q;
    logic [W-1:0]  out_data_q;
    logic          in_hs, out_hs;

    // All four permutations are pure wiring; each is written as a gather
    // (out bit <- some in bit) so the row rotate uses the inverse offset.
    logic [W-1:0] p_byp, p_tr, p_rot, p_irot, p_sel;

    genvar gy, gx;
    generate
        for (gy = 0; gy < N; gy++) begin : g_row
            for (gx = 0; gx < N; gx++) begin : g_col
                assign p_byp [gy*N + gx] = in_data[gy*N + gx];
                assign p_tr  [gy*N + gx] = in_data[gx*N + gy];
                assign p_rot [gy*N + gx] = in_data[gy*N + ((gx + N - gy) % N)];
                assign p_irot[gy*N + gx] = in_data[gy*N + ((gx + gy) % N)];
            end
        end
    endgenerate

    always_comb begin
        p_sel = p_byp;
        case (mode_q)
            2'b01:   p_sel = p_tr;
            2'b10:   p_sel = p_rot;
            2'b11:   p_sel = p_irot;
            default: p_sel = p_byp;
        endcase
    end

    // Gated with rst so the handshake outputs are quiet from the first
    // cycle reset is held, before any edge has cleared the state.
    assign in_ready  = !rst && (state == RUN) && (in_cnt < DEPTH_C)
                       && (!out_valid_q || out_ready);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid_q && out_ready;
    assign out_valid = out_valid_q && !rst;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign busy      = !rst && (state != IDLE);
    assign done      = !rst && (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (out_hs && out_last_q) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= 2'b00;
            in_cnt      <= '0;
            out_cnt     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (state == IDLE && start) begin
                mode_q  <= mode;
                in_cnt  <= '0;
                out_cnt <= '0;
            end
            // A new slice overwrites the register even when the old one
            // leaves in the same cycle, keeping out_valid high.
            if (in_hs) begin
                out_data_q  <= p_sel;
                out_last_q  <= (in_cnt == LAST_C);
                out_valid_q <= 1'b1;
                in_cnt      <= in_cnt + CW'(1);
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
            if (out_hs) out_cnt <= out_cnt + CW'(1);
        end
    end

endmodule
